data_memory_bridge: RTL and testbench

- Sits directly downstream of the processor's MEM stage; consumes its data-memory request signals (EX_MEM_MemRead, EX_MEM_MemWrite, DataMemoryAddress, DataMemoryWriteData) and returns DataMemoryReadData.
- Drives a variable-latency external word memory through a req/ack handshake.
- Retires stores through a posted write buffer.
- Stalls the pipeline for loads and for stores that arrive when the buffer is full.
- Flags misaligned word accesses as an exception.

---
 rtl/data_memory_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_data_memory_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bridge.sv
// -----------------------------------------------------------------------------
// data_memory_bridge
//
// Connects the processor's MEM-stage data-memory request to a variable-latency
// external word memory. Stores are posted into a small write buffer and retired
// in the background. Loads first drain the buffer, then issue a single read.
// The pipeline is stalled for loads and for stores that find the buffer full.
// Misaligned word accesses, and read+write together, are flagged as an exception
// and otherwise ignored.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   EX_MEM_MemRead       load request from the MEM stage
//   EX_MEM_MemWrite      store request from the MEM stage
//   DataMemoryAddress    byte address (must be word aligned)
//   DataMemoryWriteData  store data
//   DataMemoryReadData   registered load result, held until the next load
//   MemStall             freezes PC, IF/ID, ID/EX and EX/MEM while high
//   MisalignExc          combinational illegal-access flag
//   mem_req/mem_we       external request valid / write select
//   mem_addr, mem_wdata  external word address and write data
//   mem_ack, mem_rdata   external completion and read data
//   wb_count             write-buffer occupancy (0..WB_DEPTH)
// -----------------------------------------------------------------------------
module data_memory_bridge #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        EX_MEM_MemRead,
    input  logic                        EX_MEM_MemWrite,
    input  logic [ADDR_W-1:0]           DataMemoryAddress,
    input  logic [DATA_W-1:0]           DataMemoryWriteData,
    output logic [DATA_W-1:0]           DataMemoryReadData,
    output logic                        MemStall,
    output logic                        MisalignExc,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-3:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_REQ  = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    // Current FSM state; kept as a named signal so it can be probed.
    state_t state;
    state_t state_n;

    // Write buffer storage and bookkeeping.
    logic [WA_W-1:0]   buf_addr [WB_DEPTH];
    logic [DATA_W-1:0] buf_data [WB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    // Request-side decode.
    logic              illegal;
    logic              load_ok;
    logic              store_ok;
    logic              full;
    logic [WA_W-1:0]   req_word;

    // Handshake events this cycle.
    logic              push;
    logic              pop;
    logic              rd_ack;

    // Buffer state after this cycle's pop/push.
    logic [CNT_W-1:0]  count_after_pop;
    logic [CNT_W-1:0]  count_n;
    logic [PTR_W-1:0]  head_n;

    // Next values of the registered request.
    logic              req_n;
    logic              we_n;
    logic [WA_W-1:0]   addr_n;
    logic [DATA_W-1:0] wdata_n;

    logic              stall_raw;

    assign illegal  = ((EX_MEM_MemRead || EX_MEM_MemWrite) && (DataMemoryAddress[1:0] != 2'b00))
                    || (EX_MEM_MemRead && EX_MEM_MemWrite);
    assign load_ok  = EX_MEM_MemRead  && !illegal;
    assign store_ok = EX_MEM_MemWrite && !illegal;
    assign req_word = DataMemoryAddress[ADDR_W-1:2];

    // Full is taken from the registered count, so a pop in the same cycle
    // does not let a waiting store in until the following cycle.
    assign full = (count == CNT_W'(WB_DEPTH));

    // Stores are only accepted in IDLE: in every other state the MEM-stage
    // inputs still belong to the load being serviced.
    assign push = (state == IDLE) && store_ok && !full;

    // External handshake: a request (mem_req with mem_we/mem_addr/mem_wdata)
    // is offered from a register and held unchanged until the memory answers
    // with mem_ack in some cycle where mem_req is high; that cycle completes
    // the transfer. mem_ack while mem_req is low carries no meaning.
    assign pop    = mem_req &&  mem_we && mem_ack;
    assign rd_ack = mem_req && !mem_we && mem_ack;

    assign count_after_pop = count - CNT_W'(pop);
    assign count_n         = count_after_pop + CNT_W'(push);
    assign head_n          = head + PTR_W'(pop);

    // Next-state and stall decode.
    always_comb begin
        state_n   = state;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    stall_raw = 1'b1;
                    state_n   = (count != '0) ? DRAIN : RD_REQ;
                end else if (store_ok && full) begin
                    stall_raw = 1'b1;
                end
            end
            DRAIN: begin
                stall_raw = 1'b1;
                // Leave once the last buffered store is acknowledged; also
                // covers arriving here after the buffer already emptied.
                if ((count == '0) || (pop && (count == CNT_W'(1)))) begin
                    state_n = RD_REQ;
                end
            end
            RD_REQ: begin
                stall_raw = 1'b1;
                if (rd_ack) begin
                    state_n = RD_DONE;
                end
            end
            RD_DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next registered request. An outstanding request is frozen until its ack;
    // otherwise the next one is chosen from where the FSM and buffer will be
    // after this edge, so back-to-back transfers need no idle cycle.
    always_comb begin
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        if (!mem_req || mem_ack) begin
            req_n = 1'b0;
            we_n  = 1'b0;
            if (state_n == RD_REQ) begin
                req_n  = 1'b1;
                we_n   = 1'b0;
                addr_n = req_word;
            end else if (((state_n == IDLE) || (state_n == DRAIN)) && (count_n != '0)) begin
                req_n = 1'b1;
                we_n  = 1'b1;
                if (count_after_pop == '0) begin
                    // The entry being pushed this edge becomes the head; its
                    // storage is not written yet, so take it from the inputs.
                    addr_n  = req_word;
                    wdata_n = DataMemoryWriteData;
                end else begin
                    addr_n  = buf_addr[head_n];
                    wdata_n = buf_data[head_n];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            DataMemoryReadData <= '0;
        end else begin
            state     <= state_n;
            head      <= head_n;
            count     <= count_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (rd_ack && (state == RD_REQ)) begin
                DataMemoryReadData <= mem_rdata;
            end
        end
    end

    // Buffer storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= req_word;
            buf_data[tail] <= DataMemoryWriteData;
        end
    end

    assign MemStall    = stall_raw && !rst;
    assign MisalignExc = illegal   && !rst;
    assign wb_count    = count;

endmodule

// File: tb/tb_data_memory_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_memory_bridge
//
// Bench for data_memory_bridge. A processor-side driver issues loads, stores
// and illegal accesses one at a time, honouring MemStall. A memory responder
// answers requests with a configurable latency, keeps its own word memory and
// checks every write against the program-order store queue. Loads are checked
// against a program-order reference memory.
// -----------------------------------------------------------------------------
module tb_data_memory_bridge;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int WB_DEPTH = 4;
    localparam int WA_W     = ADDR_W - 2;
    localparam int W        = WA_W + DATA_W;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      EX_MEM_MemRead;
    logic                      EX_MEM_MemWrite;
    logic [ADDR_W-1:0]         DataMemoryAddress;
    logic [DATA_W-1:0]         DataMemoryWriteData;
    logic [DATA_W-1:0]         DataMemoryReadData;
    logic                      MemStall;
    logic                      MisalignExc;
    logic                      mem_req;
    logic                      mem_we;
    logic [WA_W-1:0]           mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ack;
    logic [DATA_W-1:0]         mem_rdata;
    logic [$clog2(WB_DEPTH):0] wb_count;

    data_memory_bridge #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_MemWrite     (EX_MEM_MemWrite),
        .DataMemoryAddress   (DataMemoryAddress),
        .DataMemoryWriteData (DataMemoryWriteData),
        .DataMemoryReadData  (DataMemoryReadData),
        .MemStall            (MemStall),
        .MisalignExc         (MisalignExc),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .wb_count            (wb_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;

    logic [W-1:0]      exp_q[$];              // stores in program order, {word, data}
    logic [WA_W-1:0]   exp_rd_addr = '0;      // word address of the load in flight
    logic [DATA_W-1:0] ref_mem  [logic [WA_W-1:0]];
    logic [DATA_W-1:0] resp_mem [logic [WA_W-1:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] init_word(input logic [WA_W-1:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DATA_W-1:0] ref_get(input logic [WA_W-1:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [DATA_W-1:0] resp_get(input logic [WA_W-1:0] wa);
        return resp_mem.exists(wa) ? resp_mem[wa] : init_word(wa);
    endfunction

    // ---------------- memory responder ----------------
    logic hold     = 1'b0;   // keep ack low
    logic spur     = 1'b0;   // drive ack with no request pending
    logic rand_lat = 1'b0;
    int   fixed_lat = 0;
    int   cur_lat   = 0;
    int   wcnt      = 0;

    task automatic set_lat(input int l);
        rand_lat  = 1'b0;
        fixed_lat = l;
        cur_lat   = l;
        wcnt      = 0;
    endtask

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req && !hold && (wcnt >= cur_lat)) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    check("write_pending", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("write_order", {mem_addr, mem_wdata}, exp_q.pop_front());
                    end
                    resp_mem[mem_addr] = mem_wdata;
                end else begin
                    check("read_after_drain", exp_q.size(), 0);
                    check("read_addr", mem_addr, exp_rd_addr);
                    mem_rdata = resp_get(mem_addr);
                end
                wcnt    = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end else begin
                mem_ack = spur;
                if (spur) mem_rdata = $urandom;
                if (mem_req) wcnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic exc, output logic [31:0] rdata);
        bit done;
        done = 0;
        stalls = 0;
        exc = 1'b0;
        rdata = '0;
        EX_MEM_MemRead      = rd;
        EX_MEM_MemWrite     = wr;
        DataMemoryAddress   = a;
        DataMemoryWriteData = d;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (i == 0) exc = MisalignExc;
            if (!MemStall) begin
                done  = 1;
                rdata = DataMemoryReadData;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        check("op_done", 64'(done), 1);
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        logic exc;
        logic [31:0] rv;
        ref_mem[a[31:2]] = d;
        exp_q.push_back({a[31:2], d});
        run_op(1'b0, 1'b1, a, d, stalls, exc, rv);
        check("store_no_exc", exc, 0);
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        logic exc;
        logic [31:0] rv;
        logic [31:0] exp;
        exp = ref_get(a[31:2]);
        exp_rd_addr = a[31:2];
        run_op(1'b1, 1'b0, a, 32'h0, stalls, exc, rv);
        check("load_no_exc", exc, 0);
        check("load_data", rv, exp);
        check("load_min_stall", 64'(stalls >= 2), 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (wb_count == 0 && !mem_req && exp_q.size() == 0) ok = 1;
        end
        check("drain_complete", 64'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_exc;
        logic        exp_stall;
        logic        exp_req;   // mem_req one edge after the vector
    } vec_t;

    vec_t vecs[9];

    // ---------------- main sequence ----------------
    initial begin
        int st;
        logic [31:0] held;
        bit done;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0041, 32'h1111_1111, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0080, 32'h2222_2222, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0081, 32'h3333_3333, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_00A1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0084, 32'h0000_00B2, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_008A, 32'h4444_4444, 1'b1, 1'b0, 1'b0};

        // Reset, with an illegal request on the inputs to show the gating.
        rst                 = 1'b1;
        EX_MEM_MemRead      = 1'b1;
        EX_MEM_MemWrite     = 1'b1;
        DataMemoryAddress   = 32'h3;
        DataMemoryWriteData = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exc", MisalignExc, 0);
        check("rst_stall", MemStall, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", DataMemoryReadData, 0);
        check("rst_count", wb_count, 0);
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: single-cycle accesses from IDLE with zero-wait memory.
        set_lat(0);
        for (int i = 0; i < 9; i++) begin
            EX_MEM_MemRead      = vecs[i].rd;
            EX_MEM_MemWrite     = vecs[i].wr;
            DataMemoryAddress   = vecs[i].addr;
            DataMemoryWriteData = vecs[i].data;
            if (vecs[i].wr && !vecs[i].exp_exc) begin
                ref_mem[vecs[i].addr[31:2]] = vecs[i].data;
                exp_q.push_back({vecs[i].addr[31:2], vecs[i].data});
            end
            @(negedge clk);
            check($sformatf("vec%0d_exc", i), MisalignExc, vecs[i].exp_exc);
            check($sformatf("vec%0d_stall", i), MemStall, vecs[i].exp_stall);
            @(posedge clk);
            #1;
            EX_MEM_MemRead  = 1'b0;
            EX_MEM_MemWrite = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), mem_req, vecs[i].exp_req);
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Store then load, ack latency 2: store drains first, read of word 0x10.
        set_lat(2);
        do_store(32'h40, 32'hDEAD_BEEF, st);
        check("sl_store_stall", st, 0);
        do_load(32'h40, st);
        check("sl_load_stall_cycles", st, 6);
        check("sl_rdata", DataMemoryReadData, 32'hDEAD_BEEF);
        wait_drain();

        // Zero-wait load from an empty buffer: stall 1,1,0.
        set_lat(0);
        ref_mem[30'h40]  = 32'h1234_5678;
        resp_mem[30'h40] = 32'h1234_5678;
        do_load(32'h100, st);
        check("zw_stall_cycles", st, 2);
        check("zw_rdata", DataMemoryReadData, 32'h1234_5678);

        // Fill and wrap: ack held low, fifth store must stall.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h300 + 32'(i * 4), 32'hF00D_0000 + 32'(i), st);
            check("fill_no_stall", st, 0);
        end
        @(negedge clk);
        check("fill_count", wb_count, 4);
        @(posedge clk);
        #1;
        ref_mem[30'hC4] = 32'hF00D_0004;
        exp_q.push_back({30'hC4, 32'hF00D_0004});
        EX_MEM_MemWrite     = 1'b1;
        DataMemoryAddress   = 32'h310;
        DataMemoryWriteData = 32'hF00D_0004;
        @(negedge clk);
        check("full_stall", MemStall, 1);
        check("full_count", wb_count, 4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_stall_held", MemStall, 1);
        hold = 1'b0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!MemStall) done = 1;
            @(posedge clk);
            #1;
        end
        check("full_release", 64'(done), 1);
        EX_MEM_MemWrite = 1'b0;
        wait_drain();

        // Spurious ack with no request: nothing changes.
        held = DataMemoryReadData;
        @(negedge clk);
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("spur_count", wb_count, 0);
        check("spur_req", mem_req, 0);
        check("spur_stall", MemStall, 0);
        check("spur_rdata", DataMemoryReadData, held);
        @(posedge clk);
        #1;

        // Randomised mix against the program-order model.
        rand_lat = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 99);
            a = 32'h1000 + {$urandom_range(0, 15), 2'b00};
            if (k < 50) begin
                do_store(a, $urandom, st);
            end else if (k < 82) begin
                do_load(a, st);
            end else begin
                logic exc;
                logic [31:0] rv;
                int sel;
                sel = $urandom_range(0, 2);
                if (sel == 0)      run_op(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, st, exc, rv);
                else if (sel == 1) run_op(1'b0, 1'b1, a | 32'($urandom_range(1, 3)), $urandom, st, exc, rv);
                else               run_op(1'b1, 1'b1, a, $urandom, st, exc, rv);
                check("rand_illegal_exc", exc, 1);
                check("rand_illegal_stall", st, 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();

        // Reset in the middle of RD_REQ clears everything at once.
        set_lat(0);
        hold = 1'b1;
        exp_rd_addr         = 30'h80;
        EX_MEM_MemRead      = 1'b1;
        DataMemoryAddress   = 32'h200;
        @(negedge clk);
        check("rr_stall_c0", MemStall, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rr_read_req", {mem_req, mem_we}, 2'b10);
        check("rr_rdata_nonzero", 64'(DataMemoryReadData != 0), 1);
        rst = 1'b1;
        #1;
        check("rr_req", mem_req, 0);
        check("rr_stall", MemStall, 0);
        check("rr_count", wb_count, 0);
        check("rr_rdata", DataMemoryReadData, 0);
        EX_MEM_MemRead = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_req", mem_req, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
